soc_event_dc_src: RTL
=====================

Name: soc_event_dc_src

Overview:
- Source (SoC-clock) half of the dual-clock event channel from the SoC domain to the cluster.
- Accepts a valid/ready stream of event words from the SoC event unit and stores them in a BUFFER_WIDTH-slot register array.
- Publishes a CDC-safe Johnson-coded write token, driving the cluster_events_wt/da path.
- Consumes the cluster's read token (cluster_events_rp) to compute occupancy and apply backpressure.

Parameters:
- BUFFER_WIDTH, 8, token width and number of slots; must be ≥2.
- EVNT_WIDTH, 8, event word width.
- SYNC_STAGES, 2, flops in the read-token synchronizer; must be ≥2.

Ports:
- clk_i  in  1  SoC clock
- rstn_i  in  1  asynchronous active-low reset
- evt_valid_i  in  1  event word offered
- evt_data_i  in  EVNT_WIDTH  event word
- evt_ready_o  out  1  event word accepted when high with evt_valid_i
- evt_wt_o  out  BUFFER_WIDTH  Johnson-coded write token, toward the cluster
- evt_rp_i  in  BUFFER_WIDTH  Johnson-coded read token from the cluster (asynchronous)
- evt_data_async_o  out  BUFFER_WIDTH*EVNT_WIDTH  slot array, slot s at bits [s*EVNT_WIDTH +: EVNT_WIDTH]
- evt_count_o  out  $clog2(BUFFER_WIDTH)+1  occupancy as seen from the SoC side
- evt_drop_o  out  1  sticky drop flag (feature only; otherwise tied 0)

Behaviour:
- Clock is clk_i. Reset is rstn_i: asynchronous, active-low.
- Reset values: evt_wt_o=0, all synchronizer flops=0, slot array=0, evt_count_o=0, evt_drop_o=0. evt_ready_o=1 once reset is deasserted.
- Token encoding:
  - Johnson counter with next = {t[B-2:0], ~t[B-1]}; exactly one bit changes per step.
  - Sequence has 2*B states.
  - Decode to index k: t[B-1]==0 → k=popcount(t); otherwise k=2B-popcount(t).
- Synchronization: evt_rp_i passes through SYNC_STAGES flops giving rp_s; only rp_s is decoded.
- Occupancy: count = (kw - kr) mod 2B, where kw is the decoded write index and kr is the decoded rp_s index. full = (count==B).
- evt_ready_o = !full, a combinational function of registered state only. There is no path from evt_valid_i to evt_ready_o.
- Push when evt_valid_i && evt_ready_o, on the rising edge:
  - slot[kw mod B] <= evt_data_i;
  - evt_wt_o advances one Johnson step;
  - both updates land on the same edge. The slot is stable before the receiver can observe the new token through its own synchronizer.
- Slots not being written hold their value. Slot data is never cleared except by reset.
- Latency: input word to evt_wt_o change is 1 cycle. A read-token change reaches count/ready after SYNC_STAGES cycles plus combinational decode.
- Full: with count==B, evt_ready_o=0 and the input is held. ready reasserts after the first synchronized read-token advance.
- Simultaneous push and read-token advance in the same cycle: count is unchanged, and ready stays as computed from the registered state.
- Wrap-around: index 2B-1 → 0 at token 0…0; slot index wraps B-1 → 0.
- Invalid (non-Johnson) read-token pattern after sync: decode per the rule above, with no error flagged.
- Reset mid-operation: all state returns to reset values immediately. Buffered words are lost. Both domains must be reset together.

Optional Feature:
- Macro: EVT_DROP_ON_FULL_EN.
- Defined:
  - evt_ready_o is tied 1.
  - A valid word arriving while full is discarded: no slot write, no token step.
  - evt_drop_o sets to 1 and stays set until reset.
- Undefined: backpressure exactly as in Behaviour, and evt_drop_o is tied 0.

Test Plan:
- Reset, then push 0xA5 with evt_rp_i=0 → next cycle evt_wt_o=8'b00000001, slot0=0xA5, evt_count_o=1, ready=1.
- Push 8 words 0x10..0x17 back-to-back with rp=0:
  - evt_wt_o=8'hFF, count=8, ready=0;
  - a 9th valid is held, and evt_wt_o is unchanged for 20 cycles.
- From the full state, set evt_rp_i=8'h01 → ready=1 exactly 2 cycles later (SYNC_STAGES=2). Push 0x18 → slot0=0x18, evt_wt_o=8'hFE.
- Run 40 words with rp tracking wt delayed 3 cycles:
  - no stall after the first fill;
  - evt_wt_o returns to 0 after 16 pushes;
  - slot contents match the pushed order modulo 8.
- Assert rstn_i low mid-stream with count=5 → outputs are 0 asynchronously, before the next clk_i edge. After release ready=1 and count=0.
- With EVT_DROP_ON_FULL_EN and the buffer full, offer 0xEE:
  - evt_ready_o=1;
  - no slot change, wt unchanged;
  - evt_drop_o=1 and stays 1 after the buffer drains.

Source files
------------

// File: rtl/soc_event_dc_src.sv
`default_nettype none
// ============================================================================
// Module   : soc_event_dc_src
// Brief    : SoC-side (source) half of the dual-clock event channel toward
//            the cluster. Buffers event words in a register array, publishes
//            a Johnson-coded write token and consumes the cluster's
//            synchronized read token for occupancy and backpressure.
// Options  : EVT_DROP_ON_FULL_EN - accept-always mode; words offered while
//            full are discarded and a sticky drop flag is raised.
// Revision : 1.0 - initial release
// ============================================================================
module soc_event_dc_src #(
  parameter int BUFFER_WIDTH = 8,
  parameter int EVNT_WIDTH   = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                               clk_i,
  input  logic                               rstn_i,
  input  logic                               evt_valid_i,
  input  logic [EVNT_WIDTH-1:0]              evt_data_i,
  output logic                               evt_ready_o,
  output logic [BUFFER_WIDTH-1:0]            evt_wt_o,
  input  logic [BUFFER_WIDTH-1:0]            evt_rp_i,
  output logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] evt_data_async_o,
  output logic [$clog2(BUFFER_WIDTH):0]      evt_count_o,
  output logic                               evt_drop_o
);

  // Index width covers 0 .. 2*BUFFER_WIDTH-1 (and the occupancy 0 .. B).
  localparam int              C_CW    = $clog2(BUFFER_WIDTH) + 1;
  localparam logic [C_CW:0]   C_TWO_B = (C_CW+1)'(2 * BUFFER_WIDTH);
  localparam logic [C_CW-1:0] C_B     = C_CW'(BUFFER_WIDTH);

  logic [BUFFER_WIDTH-1:0] wt_q;
  logic [BUFFER_WIDTH-1:0] wt_d;
  logic [BUFFER_WIDTH-1:0] rp_sync_q [SYNC_STAGES];

  logic [C_CW-1:0] w_kw;
  logic [C_CW-1:0] w_kr;
  logic [C_CW:0]   w_diff;
  logic [C_CW-1:0] w_count;
  logic [C_CW-1:0] w_widx;
  logic            w_full;
  logic            w_push;

  // Johnson decode: lower half counts ones, upper half counts down from 2B.
  // Non-Johnson patterns are decoded by the same rule without complaint.
  function automatic logic [C_CW-1:0] f_decode(input logic [BUFFER_WIDTH-1:0] tok);
    logic [C_CW:0] pc;
    pc = '0;
    for (int i = 0; i < BUFFER_WIDTH; i++) begin
      pc = pc + {{C_CW{1'b0}}, tok[i]};
    end
    if (tok[BUFFER_WIDTH-1]) begin
      return C_CW'(C_TWO_B - pc);
    end
    return C_CW'(pc);
  endfunction

  assign w_kw = f_decode(wt_q);
  assign w_kr = f_decode(rp_sync_q[SYNC_STAGES-1]);

  // Occupancy is the modulo-2B distance between write and read indices.
  always_comb begin
    w_diff = '0;
    if (w_kw >= w_kr) begin
      w_diff = {1'b0, w_kw} - {1'b0, w_kr};
    end else begin
      w_diff = {1'b0, w_kw} + C_TWO_B - {1'b0, w_kr};
    end
  end

  assign w_count = w_diff[C_CW-1:0];
  assign w_full  = (w_count == C_B);
  assign w_widx  = (w_kw >= C_B) ? (w_kw - C_B) : w_kw;
  assign w_push  = evt_valid_i && !w_full;

  // One Johnson step per accepted word; exactly one token bit toggles.
  assign wt_d = w_push ? {wt_q[BUFFER_WIDTH-2:0], ~wt_q[BUFFER_WIDTH-1]} : wt_q;

  // Write token register; the matching slot is written on the same edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wt_q <= '0;
    end else begin
      wt_q <= wt_d;
    end
  end

  // Read-token synchronizer; only the last stage is ever decoded.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        rp_sync_q[i] <= '0;
      end
    end else begin
      rp_sync_q[0] <= evt_rp_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        rp_sync_q[i] <= rp_sync_q[i-1];
      end
    end
  end

  generate
    for (genvar s = 0; s < BUFFER_WIDTH; s++) begin : g_slot
      logic [EVNT_WIDTH-1:0] slot_q;

      // Slot s captures the word only when the write index points at it.
      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          slot_q <= '0;
        end else if (w_push && (w_widx == C_CW'(s))) begin
          slot_q <= evt_data_i;
        end
      end

      assign evt_data_async_o[s*EVNT_WIDTH +: EVNT_WIDTH] = slot_q;
    end
  endgenerate

  assign evt_wt_o    = wt_q;
  assign evt_count_o = w_count;

`ifdef EVT_DROP_ON_FULL_EN
  logic drop_q;

  // Sticky record of any word that arrived while the buffer was full.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      drop_q <= 1'b0;
    end else if (evt_valid_i && w_full) begin
      drop_q <= 1'b1;
    end
  end

  assign evt_ready_o = 1'b1;
  assign evt_drop_o  = drop_q;
`else
  assign evt_ready_o = !w_full;
  assign evt_drop_o  = 1'b0;
`endif

endmodule
`default_nettype wire
